// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the sync/active bundle
// carried through the alignment pipe.
package vga_timing_pkg;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int axisTotal(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axisTotal(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axisTotal(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // hs/vs are carried as "asserted" flags; polarity is applied at the pins.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } sync_t;
endpackage

// File: rtl/vga_delay_line.sv
// Parameterised shift register; clears to all-zero so the delayed
// sync/active bundle reads as blanked and deasserted after reset.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pipe <= '0;
        end else begin
            pipe[0] <= iData;
            for (int i = 1; i < DEPTH; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign oData = pipe[DEPTH-1];
endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster counters, coordinate export to a colour source, and DAC output
// stage with sync/blank aligned to the source's returned colour.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter int   PIX_LATENCY = 1,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_N,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic [COORD_W-1:0] oCoord_X,
    output logic [COORD_W-1:0] oCoord_Y,
    output logic               oActive,
    output logic               oFrame_Start,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK
);
    localparam int H_TOTAL = axisTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axisTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [COORD_W-1:0] hCnt, vCnt;
    logic               active;
    sync_t              rawSync, dlySync;

    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == H_LAST) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
        end else begin
            hCnt <= hCnt + 1'b1;
        end
    end

    // Decoded straight from the counter registers, so the source sees clean coordinates.
    assign active       = (hCnt < H_VIS) && (vCnt < V_VIS);
    assign oActive      = active;
    assign oCoord_X     = active ? hCnt : '0;
    assign oCoord_Y     = active ? vCnt : '0;
    assign oFrame_Start = (hCnt == '0) && (vCnt == '0);

    assign rawSync.active = active;
    assign rawSync.hs     = (hCnt >= HS_BEG) && (hCnt < HS_END);
    assign rawSync.vs     = (vCnt >= VS_BEG) && (vCnt < VS_END);

    vga_delay_line #(
        .DEPTH (PIX_LATENCY),
        .WIDTH ($bits(sync_t))
    ) uSyncDly (
        .iVGA_CLK (iVGA_CLK),
        .iRST_N   (iRST_N),
        .iData    (rawSync),
        .oData    (dlySync)
    );

    // Single output register: colour from the source and its matching timing land together.
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R     <= '0;
            oVGA_G     <= '0;
            oVGA_B     <= '0;
            oVGA_BLANK <= 1'b0;
            oVGA_HS    <= ~SYNC_POL;
            oVGA_VS    <= ~SYNC_POL;
        end else begin
            oVGA_R     <= dlySync.active ? iRed   : '0;
            oVGA_G     <= dlySync.active ? iGreen : '0;
            oVGA_B     <= dlySync.active ? iBlue  : '0;
            oVGA_BLANK <= dlySync.active;
            oVGA_HS    <= dlySync.hs ? SYNC_POL : ~SYNC_POL;
            oVGA_VS    <= dlySync.vs ? SYNC_POL : ~SYNC_POL;
        end
    end
endmodule
